// File: rtl/axilite_master_traffic_gen.sv
// AXI4-Lite master traffic generator: writes NUM_TXN stride-spaced words, reads them
// back, and counts bad responses and data mismatches. One transaction in flight at a time.
module axilite_master_traffic_gen #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned NUM_TXN     = 16,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter logic [63:0] ADDR_STRIDE = 64'h8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             err_count,
   output logic                    resp_err
);

   localparam int unsigned    IDX_W    = $clog2(NUM_TXN) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD      = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   function automatic logic [ADDR_WIDTH-1:0] txn_addr(input logic [IDX_W-1:0] i);
      logic [63:0] full_s;
      full_s = BASE_ADDR + ADDR_STRIDE * 64'(i);
      return full_s[ADDR_WIDTH-1:0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] txn_data(input logic [IDX_W-1:0] i);
      logic [DATA_WIDTH-1:0] d_s;
      d_s = '0;
      for (int k = 0; k < int'(DATA_WIDTH / 32); k++) begin
         d_s[k*32 +: 32] = {16'hA5A5, 16'(i)};
      end
      return d_s;
   endfunction

   state_t                  state_r, state_nx_s;
   logic [IDX_W-1:0]        idx_r, idx_nx_s;
   logic [ADDR_WIDTH-1:0]   awaddr_r, araddr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [DATA_WIDTH/8-1:0] wstrb_r;
   logic                    awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
   logic                    busy_r, done_r, resp_err_r;
   logic [15:0]             err_count_r;
   logic                    start_ok_s, err_inc_s, resp_bad_s, wr_both_s;
   logic                    aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

   assign aw_hs_s    = awvalid_r & m_axi_awready;
   assign w_hs_s     = wvalid_r & m_axi_wready;
   assign b_hs_s     = bready_r & m_axi_bvalid;
   assign ar_hs_s    = arvalid_r & m_axi_arready;
   assign r_hs_s     = rready_r & m_axi_rvalid;
   assign wr_both_s  = (~awvalid_r | aw_hs_s) & (~wvalid_r | w_hs_s);
   assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

   // Next-state, next-index and error-event decode
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      err_inc_s  = 1'b0;
      resp_bad_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_ok_s) begin
               state_nx_s = ST_WR;
               idx_nx_s   = '0;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_WR: begin
            if (wr_both_s) state_nx_s = ST_WR_RESP;
            else           state_nx_s = ST_WR;
         end
         ST_WR_RESP: begin
            if (b_hs_s) begin
               resp_bad_s = (m_axi_bresp != 2'b00);
               err_inc_s  = resp_bad_s;
               if (idx_r == LAST_IDX) begin
                  idx_nx_s   = '0;
                  state_nx_s = ST_RD;
               end else begin
                  idx_nx_s   = idx_r + IDX_W'(1);
                  state_nx_s = ST_WR;
               end
            end else begin
               state_nx_s = ST_WR_RESP;
            end
         end
         ST_RD: begin
            if (ar_hs_s) state_nx_s = ST_RD_DATA;
            else         state_nx_s = ST_RD;
         end
         ST_RD_DATA: begin
            if (r_hs_s) begin
               resp_bad_s = (m_axi_rresp != 2'b00);
               // a beat with both a bad response and bad data counts once
               err_inc_s  = resp_bad_s | (m_axi_rdata != txn_data(idx_r));
               if (idx_r == LAST_IDX) begin
                  state_nx_s = ST_DONE;
               end else begin
                  idx_nx_s   = idx_r + IDX_W'(1);
                  state_nx_s = ST_RD;
               end
            end else begin
               state_nx_s = ST_RD_DATA;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            idx_nx_s   = '0;
         end
      endcase
   end

   // State, index, registered AXI outputs and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         awaddr_r    <= '0;
         araddr_r    <= '0;
         wdata_r     <= '0;
         wstrb_r     <= '0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_count_r <= 16'd0;
         resp_err_r  <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         idx_r    <= idx_nx_s;
         busy_r   <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
         done_r   <= (state_nx_s == ST_DONE);
         bready_r <= (state_nx_s == ST_WR_RESP);
         arvalid_r <= (state_nx_s == ST_RD);
         rready_r <= (state_nx_s == ST_RD_DATA);
         if ((state_nx_s == ST_WR) && (state_r != ST_WR)) begin
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            awaddr_r  <= txn_addr(idx_nx_s);
            wdata_r   <= txn_data(idx_nx_s);
            wstrb_r   <= {(DATA_WIDTH/8){1'b1}};
         end else begin
            awvalid_r <= awvalid_r & ~m_axi_awready;
            wvalid_r  <= wvalid_r & ~m_axi_wready;
         end
         if ((state_nx_s == ST_RD) && (state_r != ST_RD)) begin
            araddr_r <= txn_addr(idx_nx_s);
         end
         if (start_ok_s) begin
            err_count_r <= 16'd0;
            resp_err_r  <= 1'b0;
         end else begin
            if (err_inc_s && (err_count_r != 16'hFFFF)) err_count_r <= err_count_r + 16'd1;
            resp_err_r <= resp_err_r | resp_bad_s;
         end
      end
   end

   assign m_axi_awaddr  = awaddr_r;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wdata   = wdata_r;
   assign m_axi_wstrb   = wstrb_r;
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;
   assign m_axi_araddr  = araddr_r;
   assign m_axi_arvalid = arvalid_r;
   assign m_axi_rready  = rready_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign err_count     = err_count_r;
   assign resp_err      = resp_err_r;

endmodule
